// File: rtl/ctr_seq.sv
// Measurement sequencer for the reciprocal counter: clear, optional interpolator
// calibration, begin/end trigger handshakes around a gate time, count capture.
module ctr_seq #(
  parameter int unsigned size = 8,
  parameter int unsigned gsz  = 16,
  parameter int unsigned tsz  = 16,
  parameter int unsigned cln  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            cal,
  input  logic [gsz-1:0]  gate,
  input  logic [tsz-1:0]  tmo,
  output logic            clr,
  output logic            brq,
  output logic            erq,
  input  logic            bac,
  input  logic            eac,
  output logic            ip0,
  output logic            ip1,
  input  logic [size-1:0] cnx,
  input  logic [size-1:0] cnr,
  output logic [size-1:0] rx,
  output logic [size-1:0] rr,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned pw = $clog2(cln + 2) + 1;
  localparam logic [pw-1:0] pc_one = pw'(1);
  localparam logic [pw-1:0] pc_cal = pw'(cln - 1);

  typedef enum logic [3:0] {
    st_idle, st_clr, st_cal0, st_cal1, st_arm,
    st_gate, st_stop, st_hold, st_done, st_rls
  } state_t;

  state_t          st, st_d;
  logic [pw-1:0]   pc, pc_d;
  logic [gsz-1:0]  gc, gc_d, gl, gl_d;
  logic [tsz-1:0]  tc, tc_d, tl, tl_d;
  logic            cl, cl_d;
  logic [size-1:0] rx_d, rr_d;
  logic            err_d;
  logic            clr_d, brq_d, erq_d, ip0_d, ip1_d, busy_d, done_d;
  logic            in_run;

  // Next state, counters and captured values
  always_comb begin
    st_d  = st;
    pc_d  = pc;
    gc_d  = gc;
    tc_d  = tc;
    gl_d  = gl;
    tl_d  = tl;
    cl_d  = cl;
    rx_d  = rx;
    rr_d  = rr;
    err_d = err;
    in_run = st inside {st_clr, st_cal0, st_cal1, st_arm, st_gate, st_stop, st_hold};

    case (st)
      st_idle: begin
        if (start && !abort) begin
          st_d  = st_clr;
          gl_d  = gate;
          tl_d  = tmo;
          cl_d  = cal;
          err_d = 1'b0;
        end
      end
      st_clr: begin
        if (pc == pc_one) begin
          st_d = cl ? st_cal0 : st_arm;
          tc_d = tl;
        end else begin
          pc_d = pc + pw'(1);
        end
      end
      st_cal0: begin
        if (pc == pc_cal) st_d = st_cal1;
        else              pc_d = pc + pw'(1);
      end
      st_cal1: begin
        if (pc == pc_cal) begin
          st_d = st_arm;
          tc_d = tl;
        end else begin
          pc_d = pc + pw'(1);
        end
      end
      st_arm: begin
        if (bac) begin
          st_d = st_gate;
          gc_d = (gl == '0) ? '0 : gl - gsz'(1);
        end else if (tl != '0 && tc <= tsz'(1)) begin
          st_d  = st_done;
          err_d = 1'b1;
        end else if (tc != '0) begin
          tc_d = tc - tsz'(1);
        end
      end
      st_gate: begin
        if (gc == '0) begin
          st_d = st_stop;
          tc_d = tl;
        end else begin
          gc_d = gc - gsz'(1);
        end
      end
      st_stop: begin
        if (eac) begin
          st_d = st_hold;
        end else if (tl != '0 && tc <= tsz'(1)) begin
          st_d  = st_done;
          err_d = 1'b1;
        end else if (tc != '0) begin
          tc_d = tc - tsz'(1);
        end
      end
      st_hold: begin
        if (pc == pc_one) begin
          st_d = st_done;
          rx_d = cnx;
          rr_d = cnr;
        end else begin
          pc_d = pc + pw'(1);
        end
      end
      st_done: st_d = st_rls;
      st_rls: begin
        if (pc == pc_one) st_d = st_idle;
        else              pc_d = pc + pw'(1);
      end
      default: st_d = st_idle;
    endcase

    // Abort leaves results and error flag untouched and skips the done pulse
    if (abort && in_run) begin
      st_d  = st_rls;
      rx_d  = rx;
      rr_d  = rr;
      err_d = err;
    end

    if (st_d != st) pc_d = '0;
  end

  // Output decode from next state so the registered outputs track the state
  always_comb begin
    clr_d  = (st_d == st_clr) || (st_d == st_rls);
    ip0_d  = (st_d == st_cal0);
    ip1_d  = (st_d == st_cal1);
    brq_d  = st_d inside {st_arm, st_gate, st_stop, st_hold};
    erq_d  = st_d inside {st_stop, st_hold};
    busy_d = (st_d != st_idle);
    done_d = (st_d == st_done);
    if (st_d == st_done) begin
      brq_d = brq;
      erq_d = erq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= st_idle;
      pc   <= '0;
      gc   <= '0;
      tc   <= '0;
      gl   <= '0;
      tl   <= '0;
      cl   <= 1'b0;
      rx   <= '0;
      rr   <= '0;
      err  <= 1'b0;
      clr  <= 1'b0;
      brq  <= 1'b0;
      erq  <= 1'b0;
      ip0  <= 1'b0;
      ip1  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      st   <= st_d;
      pc   <= pc_d;
      gc   <= gc_d;
      tc   <= tc_d;
      gl   <= gl_d;
      tl   <= tl_d;
      cl   <= cl_d;
      rx   <= rx_d;
      rr   <= rr_d;
      err  <= err_d;
      clr  <= clr_d;
      brq  <= brq_d;
      erq  <= erq_d;
      ip0  <= ip0_d;
      ip1  <= ip1_d;
      busy <= busy_d;
      done <= done_d;
    end
  end

endmodule

// File: tb/tb_ctr_seq.sv
// Directed bench for ctr_seq: table of full measurements plus abort, start/abort
// collision and asynchronous reset sequences.
module tb_ctr_seq;
  localparam int unsigned size = 8;
  localparam int unsigned gsz  = 16;
  localparam int unsigned tsz  = 16;
  localparam int unsigned cln  = 4;

  logic clk = 1'b0;
  logic rst, start, abort, cal, bac, eac;
  logic [gsz-1:0]  gate;
  logic [tsz-1:0]  tmo;
  logic [size-1:0] cnx, cnr, rx, rr;
  logic clr, brq, erq, ip0, ip1, busy, done, err;

  always #5 clk = ~clk;

  ctr_seq #(.size(size), .gsz(gsz), .tsz(tsz), .cln(cln)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cal(cal),
    .gate(gate), .tmo(tmo), .clr(clr), .brq(brq), .erq(erq),
    .bac(bac), .eac(eac), .ip0(ip0), .ip1(ip1), .cnx(cnx), .cnr(cnr),
    .rx(rx), .rr(rr), .busy(busy), .done(done), .err(err)
  );

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // bd/ed: acknowledge after that many request cycles (0 = never); ab: abort on that brq cycle
  typedef struct {
    logic c; int g; int t; int bd; int ed;
    logic [7:0] x; logic [7:0] r;
    int e_ip; int e_pre; int e_erq; logic e_err;
    logic [7:0] e_rx; logic [7:0] e_rr; int e_busy;
  } vec_t;

  typedef struct {
    int clr_pre; int clr_post; int rls_bad; int ip0; int ip1; int ovl;
    int first_brq; int last_ip1; int nb; int pre; int erq; int dn; int busy; int to;
    logic derr; logic [7:0] drx; logic [7:0] drr;
  } obs_t;

  task automatic run(input logic c, input int g, input int t, input int bd, input int ed,
                     input int ab, input logic [7:0] x, input logic [7:0] r, output obs_t o);
    int ne;
    bit seen;
    bit fin;
    o = '{default: 0};
    o.first_brq = -1;
    o.last_ip1  = -1;
    ne = 0; seen = 0; fin = 0;
    @(negedge clk);
    cal = c; gate = gsz'(g); tmo = tsz'(t); cnx = x; cnr = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (busy) begin o.busy++; seen = 1; end
      if (clr) begin
        if (o.nb == 0) o.clr_pre++;
        else begin
          o.clr_post++;
          if (brq || erq) o.rls_bad++;
        end
      end
      if (ip0) o.ip0++;
      if (ip1) begin o.ip1++; o.last_ip1 = k; end
      if (ip0 && ip1) o.ovl++;
      if (brq) begin
        if (o.nb == 0) o.first_brq = k;
        o.nb++;
      end
      if (erq) ne++;
      if (brq && !erq && !done) o.pre++;
      if (erq && !done) o.erq++;
      if (done) begin o.dn++; o.derr = err; o.drx = rx; o.drr = rr; end
      bac   = (bd > 0) && (o.nb >= bd);
      eac   = (ed > 0) && (ne >= ed);
      abort = (ab > 0) && brq && (o.nb == ab);
      if (seen && !busy) begin fin = 1; break; end
      @(negedge clk);
    end
    if (!fin) o.to = 1;
    bac = 1'b0; eac = 1'b0; abort = 1'b0;
  endtask

  vec_t tv[6];
  obs_t o;
  int   nb, nc;
  bit   got;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b0, 10, 100, 3, 2, 8'd37,  8'd200, 0, 13, 4, 1'b0, 8'd37,  8'd200, 22};
    tv[1] = '{1'b1,  5,  50, 1, 1, 8'd5,   8'd9,   4,  6, 3, 1'b0, 8'd5,   8'd9,   22};
    tv[2] = '{1'b0,  0,   0, 2, 4, 8'hAA,  8'h55,  0,  3, 6, 1'b0, 8'hAA,  8'h55,  14};
    tv[3] = '{1'b0, 10,   5, 0, 2, 8'h11,  8'h22,  0,  5, 0, 1'b1, 8'hAA,  8'h55,  10};
    tv[4] = '{1'b0,  3,   4, 2, 0, 8'h33,  8'h44,  0,  5, 4, 1'b1, 8'hAA,  8'h55,  14};
    tv[5] = '{1'b1,  1,   2, 1, 1, 8'h3C,  8'hC3,  4,  2, 3, 1'b0, 8'h3C,  8'hC3,  18};

    rst = 1'b0; start = 1'b0; abort = 1'b0; cal = 1'b0; bac = 1'b0; eac = 1'b0;
    gate = '0; tmo = '0; cnx = '0; cnr = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {clr, brq, erq, ip0, ip1, busy, done, err, rx, rr}, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run(tv[i].c, tv[i].g, tv[i].t, tv[i].bd, tv[i].ed, 0, tv[i].x, tv[i].r, o);
      chk($sformatf("v%0d_timeout", i), o.to, 0);
      chk($sformatf("v%0d_clr_pre", i), o.clr_pre, 2);
      chk($sformatf("v%0d_ip0", i), o.ip0, tv[i].e_ip);
      chk($sformatf("v%0d_ip1", i), o.ip1, tv[i].e_ip);
      chk($sformatf("v%0d_ip_overlap", i), o.ovl, 0);
      if (tv[i].c) chk($sformatf("v%0d_brq_after_ip1", i), o.first_brq, o.last_ip1 + 1);
      chk($sformatf("v%0d_arm_gate", i), o.pre, tv[i].e_pre);
      chk($sformatf("v%0d_stop_hold", i), o.erq, tv[i].e_erq);
      chk($sformatf("v%0d_done", i), o.dn, 1);
      chk($sformatf("v%0d_err", i), o.derr, tv[i].e_err);
      chk($sformatf("v%0d_rx", i), o.drx, tv[i].e_rx);
      chk($sformatf("v%0d_rr", i), o.drr, tv[i].e_rr);
      chk($sformatf("v%0d_clr_rls", i), o.clr_post, 2);
      chk($sformatf("v%0d_rls_trig", i), o.rls_bad, 0);
      chk($sformatf("v%0d_busy", i), o.busy, tv[i].e_busy);
    end

    // Abort on the third gate cycle
    run(1'b0, 10, 100, 1, 0, 4, 8'h99, 8'h77, o);
    chk("abort_timeout", o.to, 0);
    chk("abort_brq_cycles", o.pre, 4);
    chk("abort_done", o.dn, 0);
    chk("abort_clr_rls", o.clr_post, 2);
    chk("abort_rls_trig", o.rls_bad, 0);
    chk("abort_busy", o.busy, 8);
    chk("abort_rx", rx, 8'h3C);
    chk("abort_rr", rr, 8'hC3);
    chk("abort_err", err, 0);

    // Start and abort together in idle
    @(negedge clk);
    start = 1'b1; abort = 1'b1; gate = gsz'(3); tmo = '0;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    nb = 0;
    for (int k = 0; k < 5; k++) begin
      if (busy || clr) nb++;
      @(negedge clk);
    end
    chk("collision_busy", nb, 0);

    // Asynchronous reset while waiting in STOP
    bac = 1'b1; eac = 1'b0;
    @(negedge clk);
    cal = 1'b0; gate = gsz'(2); tmo = '0; cnx = 8'h5A; cnr = 8'hA5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0; nc = 0;
    for (int k = 0; k < 50; k++) begin
      if (erq) begin got = 1; break; end
      @(negedge clk);
    end
    chk("rst_reach_stop", got, 1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_brq", brq, 0);
    chk("rst_async_all", {clr, brq, erq, ip0, ip1, busy, done, err, rx, rr}, 0);
    bac = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_idle", busy, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
